// File: rtl/prog_divider_counter_if.sv
// prog_divider_counter_if
// Groups the control inputs and status outputs of prog_divider_counter.
//   master : drives en/clr/dir/load/load_val/limit_wr/limit_in, observes status
//   slave  : the counter itself; drives count/limit_act/limit_pending/tc/div_out
interface prog_divider_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             clr;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             limit_wr;
    logic [WIDTH-1:0] limit_in;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] limit_act;
    logic             limit_pending;
    logic             tc;
    logic             div_out;

    modport master (
        output en, clr, dir, load, load_val, limit_wr, limit_in,
        input  count, limit_act, limit_pending, tc, div_out
    );

    modport slave (
        input  en, clr, dir, load, load_val, limit_wr, limit_in,
        output count, limit_act, limit_pending, tc, div_out
    );
endinterface

// File: rtl/prog_divider_counter.sv
// prog_divider_counter
// Up/down counter with programmable modulus, used as a tick / clock-enable
// generator. Priority per edge is clr > load > en. A new limit written via
// limit_wr is held in a shadow register and only takes effect on a wrap or
// clr, so a period already in progress never changes length.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : prog_divider_counter_if.slave
//           inputs  en, clr, dir (0 up / 1 down), load, load_val,
//                   limit_wr, limit_in
//           outputs count, limit_act, limit_pending, tc (one cycle per wrap),
//                   div_out (toggles on every wrap)
module prog_divider_counter #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] LIMIT_DEFAULT = {WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset,
    prog_divider_counter_if.slave  bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] shadow_q;
    logic             pend_q;
    logic             tc_q;
    logic             div_q;

    logic             wrap;
    logic             apply_lim;
    logic [WIDTH-1:0] new_limit;

    // Load values beyond the active limit are clamped to it, so count never
    // exceeds limit_act.
    function automatic logic [WIDTH-1:0] clamp_to_limit(
        input logic [WIDTH-1:0] val,
        input logic [WIDTH-1:0] lim
    );
        return (val > lim) ? lim : val;
    endfunction

    always_comb begin
        wrap = 1'b0;
        if (!bus.clr && !bus.load && bus.en) begin
            wrap = bus.dir ? (count_q == '0) : (count_q >= limit_q);
        end
        apply_lim = bus.clr || wrap;
        // shadow_q equals limit_q whenever nothing is pending, so it is always
        // the correct limit to install; a write on the same edge wins.
        new_limit = bus.limit_wr ? bus.limit_in : shadow_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            limit_q  <= LIMIT_DEFAULT;
            shadow_q <= LIMIT_DEFAULT;
            pend_q   <= 1'b0;
            tc_q     <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            if (apply_lim) begin
                limit_q  <= new_limit;
                shadow_q <= new_limit;
                pend_q   <= 1'b0;
            end else if (bus.limit_wr) begin
                shadow_q <= bus.limit_in;
                pend_q   <= 1'b1;
            end

            tc_q <= wrap;

            if (bus.clr) begin
                count_q <= '0;
                div_q   <= 1'b0;
            end else if (bus.load) begin
                count_q <= clamp_to_limit(bus.load_val, limit_q);
            end else if (bus.en) begin
                if (wrap) begin
                    div_q <= ~div_q;
                    // A down-wrap reloads with the limit installed on this edge.
                    count_q <= bus.dir ? new_limit : '0;
                end else begin
                    count_q <= bus.dir ? (count_q - 1'b1) : (count_q + 1'b1);
                end
            end
        end
    end

    assign bus.count         = count_q;
    assign bus.limit_act     = limit_q;
    assign bus.limit_pending = pend_q;
    assign bus.tc            = tc_q;
    assign bus.div_out       = div_q;

endmodule

// File: tb/tb_prog_divider_counter.sv
// tb_prog_divider_counter
// Directed bench for prog_divider_counter (WIDTH=8, LIMIT_DEFAULT=9).
// Stimulus pushes hand-computed expected state into a queue after each edge;
// a monitor on the falling edge pops and compares.
module tb_prog_divider_counter;

    logic clk;
    logic reset;

    prog_divider_counter_if #(.WIDTH(8)) bus ();

    prog_divider_counter #(
        .WIDTH         (8),
        .LIMIT_DEFAULT (8'd9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] count;
        logic [7:0] lim;
        logic       pend;
        logic       tc;
        logic       div;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s.%s actual=%0d expected=%0d", nm, field, act, exp);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "count", bus.count, e.count);
            chk(e.name, "limit_act", bus.limit_act, e.lim);
            chk(e.name, "limit_pending", {7'd0, bus.limit_pending}, {7'd0, e.pend});
            chk(e.name, "tc", {7'd0, bus.tc}, {7'd0, e.tc});
            chk(e.name, "div_out", {7'd0, bus.div_out}, {7'd0, e.div});
        end
    end

    task automatic drive(input logic e, input logic c, input logic d, input logic l,
                         input logic [7:0] lv, input logic lw, input logic [7:0] li);
        bus.en       = e;
        bus.clr      = c;
        bus.dir      = d;
        bus.load     = l;
        bus.load_val = lv;
        bus.limit_wr = lw;
        bus.limit_in = li;
    endtask

    task automatic expect_now(input string nm, input logic [7:0] ec, input logic [7:0] el,
                              input logic ep, input logic et, input logic ed);
        exp_t e;
        e.name  = nm;
        e.count = ec;
        e.lim   = el;
        e.pend  = ep;
        e.tc    = et;
        e.div   = ed;
        sb.push_back(e);
    endtask

    // Drive inputs, take one rising edge, record the expected post-edge state.
    task automatic step(input string nm,
                        input logic e, input logic c, input logic d, input logic l,
                        input logic [7:0] lv, input logic lw, input logic [7:0] li,
                        input logic [7:0] ec, input logic [7:0] el,
                        input logic ep, input logic et, input logic ed);
        drive(e, c, d, l, lv, lw, li);
        @(posedge clk);
        #1;
        expect_now(nm, ec, el, ep, et, ed);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 8'd0, 0, 8'd0);
        #12;
        expect_now("rst", 8'd0, 8'd9, 0, 0, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Free-running up count: 0..9, 0..9, 0..4
        for (int k = 1; k <= 24; k++)
            step($sformatf("up%0d", k), 1, 0, 0, 0, 8'd0, 0, 8'd0,
                 8'(k % 10), 8'd9, 0, (k % 10) == 0, ((k / 10) % 2) == 1);

        // Shadowed limit written at count=4
        step("shw_wr", 1, 0, 0, 0, 8'd0, 1, 8'd5, 8'd5, 8'd9, 1, 0, 0);
        for (int c = 6; c <= 9; c++)
            step($sformatf("shw_run%0d", c), 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'(c), 8'd9, 1, 0, 0);
        step("shw_wrap", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd5, 0, 1, 1);
        for (int c = 1; c <= 5; c++)
            step($sformatf("shw_p2_%0d", c), 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'(c), 8'd5, 0, 0, 1);
        step("shw_wrap2", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd5, 0, 1, 0);
        for (int c = 1; c <= 5; c++)
            step($sformatf("wrw_run%0d", c), 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'(c), 8'd5, 0, 0, 0);
        // limit_wr on the wrap edge itself applies directly
        step("wrw_wrap", 1, 0, 0, 0, 8'd0, 1, 8'd3, 8'd0, 8'd3, 0, 1, 1);
        for (int c = 1; c <= 3; c++)
            step($sformatf("wrw_p_%0d", c), 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'(c), 8'd3, 0, 0, 1);
        step("wrw_wrap2", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd3, 0, 1, 0);

        // Down count from a loaded 3 with limit 9
        step("dn_clr", 0, 1, 0, 0, 8'd0, 1, 8'd9, 8'd0, 8'd9, 0, 0, 0);
        step("dn_load", 0, 0, 0, 1, 8'd3, 0, 8'd0, 8'd3, 8'd9, 0, 0, 0);
        step("dn2", 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd2, 8'd9, 0, 0, 0);
        step("dn1", 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd1, 8'd9, 0, 0, 0);
        step("dn0", 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd0, 8'd9, 0, 0, 0);
        step("dn_wrap", 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd9, 8'd9, 0, 1, 1);
        step("dn8", 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd8, 8'd9, 0, 0, 1);
        step("dn7", 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd7, 8'd9, 0, 0, 1);
        // Pending limit during down count: wrap reloads with the new limit
        step("dn_wr", 1, 0, 1, 0, 8'd0, 1, 8'd4, 8'd6, 8'd9, 1, 0, 1);
        for (int c = 5; c >= 0; c--)
            step($sformatf("dn_pend%0d", c), 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'(c), 8'd9, 1, 0, 1);
        step("dn_wrap_new", 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd4, 8'd4, 0, 1, 0);
        step("dn_after", 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd3, 8'd4, 0, 0, 0);

        // Load clamp and priority
        step("ld_clr", 0, 1, 0, 0, 8'd0, 1, 8'd9, 8'd0, 8'd9, 0, 0, 0);
        step("ld_clamp", 0, 0, 0, 1, 8'd200, 0, 8'd0, 8'd9, 8'd9, 0, 0, 0);
        step("ld_wrap", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd9, 0, 1, 1);
        step("prio_all", 1, 1, 0, 1, 8'd5, 0, 8'd0, 8'd0, 8'd9, 0, 0, 0);
        step("prio_inc", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd1, 8'd9, 0, 0, 0);
        step("prio_ld_en", 1, 0, 0, 1, 8'd6, 0, 8'd0, 8'd6, 8'd9, 0, 0, 0);
        for (int c = 7; c <= 9; c++)
            step($sformatf("ld_run%0d", c), 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'(c), 8'd9, 0, 0, 0);
        step("ld_wrap2", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd9, 0, 1, 1);
        step("ld_after_wrap", 1, 0, 0, 1, 8'd2, 0, 8'd0, 8'd2, 8'd9, 0, 0, 1);
        step("hold_wr", 0, 0, 0, 0, 8'd0, 1, 8'd5, 8'd2, 8'd9, 1, 0, 1);
        step("ld_pend", 0, 0, 0, 1, 8'd7, 0, 8'd0, 8'd7, 8'd9, 1, 0, 1);
        step("ld_pend_clamp", 0, 0, 0, 1, 8'd200, 0, 8'd0, 8'd9, 8'd9, 1, 0, 1);
        step("clr_apply", 0, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd5, 0, 0, 0);

        // Limit 0: tc constantly high, div_out toggles every cycle
        step("l0_wr", 0, 0, 0, 0, 8'd0, 1, 8'd0, 8'd0, 8'd5, 1, 0, 0);
        step("l0_clr", 0, 1, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 0);
        for (int k = 1; k <= 4; k++)
            step($sformatf("l0_up%0d", k), 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 1, (k % 2) == 1);
        step("l0_dn", 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd0, 8'd0, 0, 1, 1);

        // Direction change mid-count
        step("dc_clr", 0, 1, 0, 0, 8'd0, 1, 8'd9, 8'd0, 8'd9, 0, 0, 0);
        step("dc_up1", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd1, 8'd9, 0, 0, 0);
        step("dc_up2", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd2, 8'd9, 0, 0, 0);
        step("dc_dn1", 1, 0, 1, 0, 8'd0, 0, 8'd0, 8'd1, 8'd9, 0, 0, 0);
        step("dc_up2b", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd2, 8'd9, 0, 0, 0);

        // Reset mid-operation with count=7, div_out=1 and a limit pending
        step("rm_load9", 0, 0, 0, 1, 8'd9, 0, 8'd0, 8'd9, 8'd9, 0, 0, 0);
        step("rm_wrap", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd9, 0, 1, 1);
        step("rm_load7", 0, 0, 0, 1, 8'd7, 0, 8'd0, 8'd7, 8'd9, 0, 0, 1);
        step("rm_wr", 0, 0, 0, 0, 8'd0, 1, 8'd3, 8'd7, 8'd9, 1, 0, 1);
        drive(0, 0, 0, 0, 8'd0, 0, 8'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        expect_now("rst_mid", 8'd0, 8'd9, 0, 0, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        for (int c = 1; c <= 9; c++)
            step($sformatf("post_rst%0d", c), 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'(c), 8'd9, 0, 0, 0);
        step("post_rst_wrap", 1, 0, 0, 0, 8'd0, 0, 8'd0, 8'd0, 8'd9, 0, 1, 1);

        drive(0, 0, 0, 0, 8'd0, 0, 8'd0);
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            $display("FAIL %s.unchecked actual=none expected=compared", e.name);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
